riscv_muldiv_unit: RTL and testbench



---
 rtl/riscv_pkg.sv | 36 +++
 rtl/riscv_muldiv_unit_if.sv | 23 ++
 rtl/riscv_div_iter.sv | 45 ++++
 rtl/riscv_muldiv_unit.sv | 153 +++++++++++++++
 tb/tb_riscv_muldiv_unit.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: data width, M-extension funct3/funct7 encodings and
// the mul/div unit's state and operation types.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  typedef enum logic [2:0] {
    OP_MUL    = FUNCT3_MUL,
    OP_MULH   = FUNCT3_MULH,
    OP_MULHSU = FUNCT3_MULHSU,
    OP_MULHU  = FUNCT3_MULHU,
    OP_DIV    = FUNCT3_DIV,
    OP_DIVU   = FUNCT3_DIVU,
    OP_REM    = FUNCT3_REM,
    OP_REMU   = FUNCT3_REMU
  } muldiv_op_e;

endpackage

// File: rtl/riscv_muldiv_unit_if.sv
// Request/response handshake bundle between the execute stage and the mul/div unit.
interface riscv_muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, funct3, op_a, op_b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, funct3, op_a, op_b, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/riscv_div_iter.sv
// Restoring divider on unsigned magnitudes, one quotient bit per step.
// quot_c/rem_c are the values the registers take on the current step.
module riscv_div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quot_c,
  output logic [XLEN-1:0] rem_c
);

  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] dvsr_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            fits;

  // Quotient register doubles as the dividend shift-out register.
  assign shifted = {rem_q, quot_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvsr_q};
  assign fits    = ~diff[XLEN];
  assign rem_c   = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quot_c  = {quot_q[XLEN-2:0], fits};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
    end else if (start) begin
      rem_q  <= '0;
      quot_q <= dividend;
      dvsr_q <= divisor;
    end else if (step) begin
      rem_q  <= rem_c;
      quot_q <= quot_c;
    end
  end

endmodule

// File: rtl/riscv_muldiv_unit.sv
// RV32M/RV64M multiply/divide execution unit: iterative shift-add multiply (or
// single-cycle product), restoring divide, one-cycle early-out for div corner cases.
module riscv_muldiv_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN     = riscv_pkg::XLEN,
  parameter bit          FAST_MUL = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                kill,
  riscv_muldiv_unit_if.slave  bus
);

  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam int unsigned W2 = 2 * XLEN;

  function automatic logic [XLEN-1:0] neg_if(input logic c, input logic [XLEN-1:0] x);
    return c ? XLEN'(~x + 1'b1) : x;
  endfunction

  muldiv_state_e   state;
  muldiv_op_e      op_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_a_q;
  logic            neg_b_q;
  logic [W2-1:0]   acc_q;
  logic [XLEN-1:0] mcand_q;

  muldiv_op_e      op_in;
  logic            is_div_in, a_neg_in, b_neg_in, div_zero_in, ovf_in, early_in, accept;
  logic [XLEN-1:0] mag_a, mag_b, early_res, fast_res;
  logic [W2-1:0]   fast_prod, fast_fix;

  // Request decode, operand magnitudes and early-out detection.
  assign op_in       = muldiv_op_e'(bus.funct3);
  assign is_div_in   = bus.funct3[2];
  assign a_neg_in    = bus.op_a[XLEN-1] &&
                       (op_in == OP_MULH || op_in == OP_MULHSU || op_in == OP_DIV || op_in == OP_REM);
  assign b_neg_in    = bus.op_b[XLEN-1] && (op_in == OP_MULH || op_in == OP_DIV || op_in == OP_REM);
  assign mag_a       = neg_if(a_neg_in, bus.op_a);
  assign mag_b       = neg_if(b_neg_in, bus.op_b);
  assign div_zero_in = is_div_in && (bus.op_b == '0);
  assign ovf_in      = (op_in == OP_DIV || op_in == OP_REM) &&
                       (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
  assign early_in    = div_zero_in || ovf_in;
  assign early_res   = div_zero_in ? (bus.funct3[1] ? bus.op_a : '1)
                                   : (bus.funct3[1] ? '0 : bus.op_a);
  assign accept      = bus.in_valid && in_ready_q && !kill;

  assign fast_prod = W2'(mag_a) * W2'(mag_b);
  assign fast_fix  = (a_neg_in ^ b_neg_in) ? W2'(~fast_prod + 1'b1) : fast_prod;
  assign fast_res  = (op_in == OP_MUL) ? fast_fix[XLEN-1:0] : fast_fix[W2-1:XLEN];

  logic [XLEN:0]   mul_sum;
  logic [W2-1:0]   acc_nxt, mul_fix;
  logic [XLEN-1:0] mul_res, div_res, calc_res, quot_c, rem_c;
  logic            last;

  // Shift-add step: add multiplicand into the high half when the multiplier LSB is set.
  assign mul_sum  = {1'b0, acc_q[W2-1:XLEN]} + ({1'b0, mcand_q} & {(XLEN+1){acc_q[0]}});
  assign acc_nxt  = {mul_sum, acc_q[XLEN-1:1]};
  assign mul_fix  = (neg_a_q ^ neg_b_q) ? W2'(~acc_nxt + 1'b1) : acc_nxt;
  assign mul_res  = (op_q == OP_MUL) ? mul_fix[XLEN-1:0] : mul_fix[W2-1:XLEN];
  assign div_res  = op_q[1] ? neg_if(neg_a_q, rem_c) : neg_if(neg_a_q ^ neg_b_q, quot_c);
  assign calc_res = op_q[2] ? div_res : mul_res;
  assign last     = (cnt_q == CW'(XLEN - 1));

  riscv_div_iter #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (accept && is_div_in && !early_in),
    .step     (state == CALC && op_q[2]),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quot_c   (quot_c),
    .rem_c    (rem_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= OP_MUL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cnt_q       <= '0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
    end else if (kill) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cnt_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q       <= op_in;
            neg_a_q    <= a_neg_in;
            neg_b_q    <= b_neg_in;
            cnt_q      <= '0;
            acc_q      <= {XLEN'(0), mag_b};
            mcand_q    <= mag_a;
            in_ready_q <= 1'b0;
            if (early_in) begin
              result_q    <= early_res;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else if (FAST_MUL && !is_div_in) begin
              result_q    <= fast_res;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (cnt_q != CW'(XLEN)) cnt_q <= cnt_q + CW'(1);
          if (!op_q[2]) acc_q <= acc_nxt;
          if (last) begin
            result_q    <= calc_res;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed bench for riscv_muldiv_unit: iterative and single-cycle multiply,
// divide with sign fixups, corner cases, backpressure, kill and reset abort.
module tb_riscv_muldiv_unit;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic kill;
  logic kill_f;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  riscv_muldiv_unit_if #(.XLEN(32)) bus_s ();
  riscv_muldiv_unit_if #(.XLEN(32)) bus_f ();

  riscv_muldiv_unit #(.XLEN(32), .FAST_MUL(1'b0)) u_slow (
    .clk (clk), .rst (rst), .kill (kill), .bus (bus_s)
  );
  riscv_muldiv_unit #(.XLEN(32), .FAST_MUL(1'b1)) u_fast (
    .clk (clk), .rst (rst), .kill (kill_f), .bus (bus_f)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic start_op(input bit fast, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b);
    if (fast) begin
      bus_f.in_valid = 1'b1; bus_f.funct3 = f3; bus_f.op_a = a; bus_f.op_b = b;
    end else begin
      bus_s.in_valid = 1'b1; bus_s.funct3 = f3; bus_s.op_a = a; bus_s.op_b = b;
    end
    @(posedge clk); #1;
    if (fast) bus_f.in_valid = 1'b0;
    else      bus_s.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input bit fast, input string tag,
                            output int lat, output logic [31:0] res);
    logic ov;
    lat = 1;
    ov  = fast ? bus_f.out_valid : bus_s.out_valid;
    while (!ov && lat < 80) begin
      @(posedge clk); #1;
      lat++;
      ov = fast ? bus_f.out_valid : bus_s.out_valid;
    end
    res = fast ? bus_f.result : bus_s.result;
    check({tag, "_valid"}, 32'(ov), 32'd1);
  endtask

  task automatic run_op(input string tag, input bit fast, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int          lat;
    logic [31:0] res;
    start_op(fast, f3, a, b);
    wait_valid(fast, tag, lat, res);
    check(tag, res, exp);
    if (exp_lat > 0) check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    @(posedge clk); #1;
  endtask

  initial begin
    int          lat;
    int          seen;
    logic [31:0] res;

    rst = 1'b1; kill = 1'b0; kill_f = 1'b0;
    bus_s.in_valid = 1'b0; bus_s.funct3 = '0; bus_s.op_a = '0; bus_s.op_b = '0; bus_s.out_ready = 1'b1;
    bus_f.in_valid = 1'b0; bus_f.funct3 = '0; bus_f.op_a = '0; bus_f.op_b = '0; bus_f.out_ready = 1'b1;
    #2;
    check("rst_in_ready", 32'(bus_s.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus_s.out_valid), 32'd0);
    check("rst_result", bus_s.result, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", 32'(bus_s.in_ready), 32'd1);

    // Multiplies
    run_op("mul_slow",   1'b0, FUNCT3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mul_fast",   1'b1, FUNCT3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1);
    run_op("mulh",       1'b0, FUNCT3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("mulh_fast",  1'b1, FUNCT3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1);
    run_op("mulhu",      1'b0, FUNCT3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulhsu",     1'b0, FUNCT3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run_op("mulhsu_fast",1'b1, FUNCT3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);

    // Divides
    run_op("div_neg",    1'b0, FUNCT3_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run_op("rem_neg",    1'b0, FUNCT3_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_op("divu",       1'b0, FUNCT3_DIVU, 32'd7,        32'd2, 32'd3, 33);
    run_op("remu",       1'b0, FUNCT3_REMU, 32'd7,        32'd2, 32'd1, 33);
    run_op("div_negb",   1'b0, FUNCT3_DIV,  32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 33);
    run_op("rem_negb",   1'b0, FUNCT3_REM,  32'd100, 32'hFFFFFFF9, 32'd2, 33);
    run_op("div_fastcfg",1'b1, FUNCT3_DIVU, 32'd7,        32'd2, 32'd3, 33);

    // Early-out corner cases
    run_op("div_by0",    1'b0, FUNCT3_DIV,  32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_op("rem_by0",    1'b0, FUNCT3_REM,  32'd5, 32'd0, 32'd5, 1);
    run_op("divu_by0",   1'b0, FUNCT3_DIVU, 32'd9, 32'd0, 32'hFFFFFFFF, 1);
    run_op("remu_by0",   1'b0, FUNCT3_REMU, 32'd9, 32'd0, 32'd9, 1);
    run_op("div_ovf",    1'b0, FUNCT3_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",    1'b0, FUNCT3_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

    // Backpressure: result held, no new accept until handshake
    bus_s.out_ready = 1'b0;
    start_op(1'b0, FUNCT3_DIVU, 32'd7, 32'd2);
    wait_valid(1'b0, "bp", lat, res);
    check("bp_result", res, 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_result", bus_s.result, 32'd3);
      check("bp_hold_valid", 32'(bus_s.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus_s.in_ready), 32'd0);
    end
    bus_s.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", 32'(bus_s.in_ready), 32'd1);
    check("bp_release_valid", 32'(bus_s.out_valid), 32'd0);
    run_op("b2b_remu", 1'b0, FUNCT3_REMU, 32'd7, 32'd2, 32'd1, 33);

    // kill with in_valid in IDLE must not accept
    bus_s.in_valid = 1'b1; bus_s.funct3 = FUNCT3_DIV; bus_s.op_a = 32'd5; bus_s.op_b = 32'd0;
    kill = 1'b1;
    @(posedge clk); #1;
    bus_s.in_valid = 1'b0; kill = 1'b0;
    check("kill_idle_valid", 32'(bus_s.out_valid), 32'd0);
    check("kill_idle_ready", 32'(bus_s.in_ready), 32'd1);

    // kill in DONE beats out_ready
    bus_s.out_ready = 1'b0;
    start_op(1'b0, FUNCT3_DIV, 32'd5, 32'd0);
    wait_valid(1'b0, "kdone", lat, res);
    kill = 1'b1; bus_s.out_ready = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_done_valid", 32'(bus_s.out_valid), 32'd0);
    check("kill_done_ready", 32'(bus_s.in_ready), 32'd1);

    // kill in cycle 10 of a DIV
    start_op(1'b0, FUNCT3_DIV, 32'hFFFFFFF9, 32'd2);
    repeat (9) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_calc_ready", 32'(bus_s.in_ready), 32'd1);
    check("kill_calc_valid", 32'(bus_s.out_valid), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus_s.out_valid) seen++;
    end
    check("kill_no_valid", 32'(seen), 32'd0);
    run_op("after_kill", 1'b0, FUNCT3_DIV, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 33);

    // Asynchronous reset mid-CALC
    start_op(1'b0, FUNCT3_MUL, 32'd7, 32'hFFFFFFFD);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("arst_in_ready", 32'(bus_s.in_ready), 32'd1);
    check("arst_out_valid", 32'(bus_s.out_valid), 32'd0);
    check("arst_result", bus_s.result, 32'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    run_op("after_rst", 1'b0, FUNCT3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
